ifu_fetch: RTL and testbench

//  Instruction-fetch unit with a PC register and next-PC logic; feeds the decode/extend stage.

---
 rtl/ifu_pkg.sv | 27 ++
 rtl/ifu_npc_calc.sv | 39 +++
 rtl/ifu_fetch.sv | 125 ++++++++++++
 tb/tb_ifu_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared encodings for the instruction-fetch unit.
//   - npc_sel encodings (NPC_SEQ / NPC_BR / NPC_J / NPC_JR)
//   - fetch FSM state encodings (IDLE / FETCH / ISSUE / ERR)
//   - default reset PC
package ifu_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'b00,
      NPC_BR  = 2'b01,
      NPC_J   = 2'b10,
      NPC_JR  = 2'b11
   } npc_sel_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      ISSUE = 2'b10,
      ERR   = 2'b11
   } ifu_state_e;

   function automatic logic word_aligned(input logic [31:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/ifu_npc_calc.sv
// npc_calc: combinational next-PC selection.
//   pc           in   current PC
//   npc_sel      in   NPC_SEQ / NPC_BR / NPC_J / NPC_JR
//   branch_taken in   branch condition, used only for NPC_BR
//   ext_imm      in   sign/zero-extended immediate (word offset)
//   instr_idx    in   instr[25:0] jump index
//   jr_target    in   register target for jr
//   pc_plus4     out  pc + 4
//   npc          out  selected next PC (all arithmetic wraps mod 2^32)
module npc_calc
   import ifu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  npc_sel,
   input  logic        branch_taken,
   input  logic [31:0] ext_imm,
   input  logic [25:0] instr_idx,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] npc
);

   logic [31:0] br_target;

   assign pc_plus4  = pc + 32'd4;
   assign br_target = pc_plus4 + {ext_imm[29:0], 2'b00};

   always_comb begin
      npc = pc_plus4;
      unique case (npc_sel_e'(npc_sel))
         NPC_SEQ: npc = pc_plus4;
         NPC_BR:  npc = branch_taken ? br_target : pc_plus4;
         NPC_J:   npc = {pc_plus4[31:28], instr_idx, 2'b00};
         NPC_JR:  npc = jr_target;
         default: npc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit. Holds the PC and fetched instruction,
// fetches one word per req/ack handshake, issues it with valid/ready and
// then advances the PC using npc_calc.
//   clk, reset        clock, synchronous active-high reset
//   imem_req/addr     fetch request and address (= pc), held until ack
//   imem_ack/rdata    memory response
//   instr_valid/ready issue handshake to decode
//   instr, imm16, pc, pc_plus4  held instruction and derived fields
//   npc_sel, branch_taken, ext_imm, jr_target  next-PC controls
//   fetch_err         sticky misaligned-next-PC flag
// Optional feature macro: IFU_ALIGN_CHECK_EN (misaligned-npc trap into ERR).
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [15:0] imm16,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  npc_sel,
   input  logic        branch_taken,
   input  logic [31:0] ext_imm,
   input  logic [31:0] jr_target,
   output logic        fetch_err
);

   ifu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] npc;

   npc_calc u_npc (
      .pc           (pc_q),
      .npc_sel      (npc_sel),
      .branch_taken (branch_taken),
      .ext_imm      (ext_imm),
      .instr_idx    (instr_q[25:0]),
      .jr_target    (jr_target),
      .pc_plus4     (pc_plus4),
      .npc          (npc)
   );

`ifdef IFU_ALIGN_CHECK_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
`ifdef IFU_ALIGN_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ready) begin
`ifdef IFU_ALIGN_CHECK_EN
               // misaligned target: keep pc pointing at the offending instr
               if (!word_aligned(npc)) begin
                  err_d   = 1'b1;
                  state_d = ERR;
               end else begin
                  pc_d    = npc;
                  state_d = FETCH;
               end
`else
               pc_d    = npc;
               state_d = FETCH;
`endif
            end
         end
`ifdef IFU_ALIGN_CHECK_EN
         ERR:     state_d = ERR;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
`ifdef IFU_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
`ifdef IFU_ALIGN_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ISSUE);
   assign instr       = instr_q;
   assign imm16       = instr_q[15:0];
   assign pc          = pc_q;
`ifdef IFU_ALIGN_CHECK_EN
   assign fetch_err   = err_q;
`else
   assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed plus randomized bench for ifu_fetch. Inputs change
// and outputs are sampled on the falling clock edge. A PC/instr model
// computed from the next-PC rules supplies every expected value.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [15:0] imm16;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  npc_sel;
   logic        branch_taken;
   logic [31:0] ext_imm;
   logic [31:0] jr_target;
   logic        fetch_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] pc_m;
   logic [31:0] instr_m;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .imm16        (imm16),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .npc_sel      (npc_sel),
      .branch_taken (branch_taken),
      .ext_imm      (ext_imm),
      .jr_target    (jr_target),
      .fetch_err    (fetch_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Next PC from the architectural rules, plain arithmetic mod 2^32.
   function automatic logic [31:0] ref_npc(input logic [31:0] p, input int sel, input logic tk,
                                           input logic [31:0] ext, input logic [31:0] ins,
                                           input logic [31:0] jr);
      logic [31:0] p4;
      p4 = p + 32'd4;
      case (sel)
         0:       return p4;
         1:       return tk ? p4 + ext * 32'd4 : p4;
         2:       return (p4 & 32'hF000_0000) + (ins % 32'h0400_0000) * 32'd4;
         default: return jr;
      endcase
   endfunction

   task automatic chk_held(input string tag);
      chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      chk({tag, "_instr"}, instr, instr_m);
      chk({tag, "_imm16"}, {16'd0, imm16}, instr_m % 32'h1_0000);
      chk({tag, "_pc"}, pc, pc_m);
      chk({tag, "_pc4"}, pc_plus4, pc_m + 32'd4);
   endtask

   task automatic do_reset();
      reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0;
      tick(); tick();
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_instr", instr, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      reset = 1'b0;
      chk("rel_req0", {31'd0, imem_req}, 32'd0);
      tick();
      chk("rel_req1", {31'd0, imem_req}, 32'd1);
      chk("rel_addr", imem_addr, 32'h0000_3000);
      pc_m = 32'h0000_3000;
      instr_m = 32'd0;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 10) begin tick(); n++; end
      chk("req_timeout", {31'd0, imem_req}, 32'd1);
   endtask

   // Serve one fetch after wcyc wait states; instr_ready toggles randomly
   // meanwhile and must be ignored outside ISSUE.
   task automatic fetch(input logic [31:0] w, input int wcyc);
      wait_req();
      repeat (wcyc) begin
         instr_ready = 1'($urandom);
         chk("fw_addr", imem_addr, pc_m);
         chk("fw_valid", {31'd0, instr_valid}, 32'd0);
         tick();
         chk("fw_req", {31'd0, imem_req}, 32'd1);
      end
      imem_ack = 1'b1; imem_rdata = w;
      chk("f_addr", imem_addr, pc_m);
      chk("f_valid0", {31'd0, instr_valid}, 32'd0);
      tick();
      imem_ack = 1'b0; instr_ready = 1'b0;
      instr_m = w;
      chk_held("f");
   endtask

   task automatic issue(input int sel, input logic tk, input logic [31:0] ext,
                        input logic [31:0] jr, input int hold);
      logic [31:0] exp;
      repeat (hold) begin tick(); chk_held("hold"); end
      npc_sel = 2'(sel); branch_taken = tk; ext_imm = ext; jr_target = jr;
      instr_ready = 1'b1;
      exp = ref_npc(pc_m, sel, tk, ext, instr_m, jr);
      tick();
      instr_ready = 1'b0;
      pc_m = exp;
      chk("i_pc", pc, pc_m);
      chk("i_valid", {31'd0, instr_valid}, 32'd0);
      chk("i_req", {31'd0, imem_req}, 32'd1);
      chk("i_addr", imem_addr, pc_m);
   endtask

   initial begin
      reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
      npc_sel = '0; branch_taken = 1'b0; ext_imm = '0; jr_target = '0;
      pc_m = 32'h0000_3000; instr_m = '0;

      // reset and first fetch
      do_reset();
      fetch(32'h2408_0005, 0);
      chk("t2_instr", instr, 32'h2408_0005);
      chk("t2_imm16", {16'd0, imm16}, 32'h0000_0005);
      issue(0, 1'b0, 32'd0, 32'd0, 3);
      chk("t2_pc", pc, 32'h0000_3004);

      // branches
      fetch(32'h1000_FFFF, 0);
      issue(0, 1'b0, 32'd0, 32'd0, 0);
      fetch(32'h1000_FFFF, 1);
      issue(1, 1'b1, 32'hFFFF_FFFF, 32'd0, 0);
      chk("t3_taken", pc, 32'h0000_3008);
      fetch(32'h1000_FFFF, 0);
      issue(1, 1'b0, 32'hFFFF_FFFF, 32'd0, 0);
      chk("t3_ntaken", pc, 32'h0000_300C);

      // jump and jr
      do_reset();
      fetch(32'h0800_0C10, 0);
      issue(2, 1'b0, 32'd0, 32'd0, 0);
      chk("t4_j", pc, 32'h0000_3040);
      fetch(32'h0000_0008, 0);
      issue(3, 1'b0, 32'd0, 32'h0000_3100, 0);
      chk("t4_jr", pc, 32'h0000_3100);

      // reset dominates a simultaneous ack
      wait_req();
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      reset = 1'b0; imem_ack = 1'b0;
      chk("t5_valid", {31'd0, instr_valid}, 32'd0);
      chk("t5_pc", pc, 32'h0000_3000);
      chk("t5_instr", instr, 32'd0);
      chk("t5_idle", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t5_valid2", {31'd0, instr_valid}, 32'd0);
      chk("t5_req", {31'd0, imem_req}, 32'd1);
      pc_m = 32'h0000_3000; instr_m = 32'd0;

      // stray ack while issuing
      fetch(32'h1111_2222, 0);
      imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
      tick();
      imem_ack = 1'b0;
      chk("t5_stray", instr, 32'h1111_2222);
      chk_held("t5_stray");
      issue(0, 1'b0, 32'd0, 32'd0, 0);

      // randomized traffic with word-aligned targets
      for (int i = 0; i < 40; i++) begin
         fetch($urandom, int'($urandom_range(0, 3)));
         issue(int'($urandom_range(0, 3)), 1'($urandom), $urandom,
               $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 2)));
      end

      // misaligned jr target
      do_reset();
      fetch(32'h0000_0008, 0);
`ifdef IFU_ALIGN_CHECK_EN
      npc_sel = 2'b11; jr_target = 32'h0000_3002; instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk("t6_err", {31'd0, fetch_err}, 32'd1);
      chk("t6_pc", pc, pc_m);
      chk("t6_valid", {31'd0, instr_valid}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         imem_ack = 1'b1;
         tick();
         chk("t6_noreq", {31'd0, imem_req}, 32'd0);
         chk("t6_sticky", {31'd0, fetch_err}, 32'd1);
      end
      imem_ack = 1'b0;
      do_reset();
`else
      issue(3, 1'b0, 32'd0, 32'h0000_3002, 0);
      chk("t6_addr", imem_addr, 32'h0000_3002);
      chk("t6_err", {31'd0, fetch_err}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
